uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-requester UART transmit scheduler for the photo-frame FPGA. It arbitrates round-robin between two byte sources, such as the status reporter and the image-transfer acknowledger, and serialises the granted byte onto `txd` as 8N1. Bit timing is derived from the divider's 16× oversample clock (nominal 153.6 kHz, 326-cycle period at 50 MHz), which the block samples synchronously in the `clk_50m` domain.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame, sent LSB first.
- `OVERSAMPLE`, 16: oversample ticks per bit period.

Ports:
- `clk_50m` in 1: system clock, 50 MHz.
- `rst` in 1: reset, synchronous and active-high.
- `uart_clk16` in 1: 16× baud square wave from the clock divider. It is synchronous to `clk_50m`, so no CDC is needed.
- `req0`, `req1` in 1: transmit requests, held high until the matching ack.
- `data0`, `data1` in `DATA_BITS`: payload for each requester, held stable while its req is high.
- `ack0`, `ack1` out 1: one-cycle pulse; the matching data is captured in this cycle.
- `txd` out 1: serial line, idle high.
- `busy` out 1: high from the grant cycle through the end of the stop bit.
- `grant_id` out 1: requester that owns the current or most recent frame.
- `done` out 1: one-cycle pulse on the final tick of the stop bit.

## Operation
- Tick generation:
  - `tick = uart_clk16 & ~clk16_q`, where `clk16_q` is `uart_clk16` registered.
  - `clk16_q` resets to 1, so no spurious tick fires on the first cycle after reset.
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - `txd` = 1, `busy` = 0.
  - When any req is high, grant it in the same cycle.
  - Arbitration uses a round-robin pointer `last`, reset value 1. With both reqs high, grant the requester ≠ `last`. With one req high, grant that one.
  - In the grant cycle: pulse `ack[g]`, latch `data[g]` into the shift register, set `grant_id` = g, set `last` = g, clear the oversample counter `os` (width clog2(OVERSAMPLE)). Next state is START.
- START: `txd` = 0. After OVERSAMPLE ticks, go to DATA with `bitcnt` = 0.
- DATA:
  - `txd` = `shreg[0]`.
  - Every OVERSAMPLE ticks, shift the register right and increment `bitcnt`.
  - After bit DATA_BITS−1 completes, go to STOP.
- STOP:
  - `txd` = 1.
  - On the OVERSAMPLE-th tick, pulse `done` and return to IDLE.
  - A pending req is granted on the next cycle, leaving a one-cycle IDLE gap.
- `os` increments only on tick and wraps from OVERSAMPLE−1 to 0; the wrap marks a bit boundary.
- Requests that arrive while busy are not acked. They stay pending and are arbitrated in IDLE.
- A req that drops before its ack is simply never granted, with no error.
- Reset mid-frame:
  - Next edge: state IDLE, `txd` = 1, `busy` = 0, all acks and `done` = 0.
  - `last` = 1, `grant_id` = 0.
  - The partial frame is abandoned and not retried.
- Reset values: `txd` 1, `busy` 0, `ack0`/`ack1` 0, `done` 0, `grant_id` 0.

## Timing
- Tick spacing is 326 `clk_50m` cycles.
- Bit period is OVERSAMPLE × 326 = 5216 cycles, which is 9585.9 baud.
- Grant latency: ack and the START entry happen 1 cycle after req is seen in IDLE. `txd` falls on the edge after the grant cycle.
- Start bit length: 15 to 16 tick intervals, because the grant is not tick-aligned. All later bits are exactly OVERSAMPLE ticks long.
- Frame from grant to `done` is 9 full bits plus the partial start bit, roughly 51,900 to 52,160 cycles.
- When `done` and a new req occur together, the new req is acked 1 cycle after `done`.
- ack, `done` and tick are each exactly one cycle wide.

## Test plan
- Single frame: `req0` with `data0` = 0x55 in IDLE.
  - `ack0` pulses once, `grant_id` = 0.
  - `txd` = 0, 1,0,1,0,1,0,1,0, 1, sampled at mid-bit every 5216 cycles.
  - `done` pulses once and `busy` falls.
- Tie after reset: `req0` and `req1` rise in the same cycle with `data0` = 0xA0 and `data1` = 0x0B.
  - `req0` is served first, then `req1`, one cycle after `done`.
  - A second tie after that is served `req0` first again.
- Back-to-back: `req1` held continuously with `data1` = 0xFF then 0x00.
  - Exactly two acks.
  - Exactly one IDLE cycle between `done` and the second ack.
  - `txd` stays 1 across the gap.
- Request during busy: `req1` rises mid-DATA of a `req0` frame.
  - No `ack1` before `done`.
  - `ack1` arrives at `done`+1.
- Reset mid-DATA: assert `rst` for 1 cycle during bit 4.
  - `txd` = 1, `busy` = 0, `grant_id` = 0 on the next edge.
  - No `done`.
  - Held `req0` is re-granted 1 cycle after reset releases.
- Reset with `uart_clk16` high: release `rst` while `uart_clk16` = 1.
  - No tick in the first cycle.
  - The first tick occurs on the next rising edge of `uart_clk16`.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmit scheduler; serialises the granted byte as 8N1
// using bit timing taken from a synchronous 16x oversample square wave.
module uart_tx_sched #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk_50m,
   input  logic                 rst,
   input  logic                 uart_clk16,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [DATA_BITS-1:0] data0,
   input  logic [DATA_BITS-1:0] data1,
   output logic                 ack0,
   output logic                 ack1,
   output logic                 txd,
   output logic                 busy,
   output logic                 grant_id,
   output logic                 done
);

   localparam int unsigned OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t               state_q, state_d;
   logic                 clk16_q, clk16_d;
   logic [OS_W-1:0]      os_q, os_d;
   logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 last_q, last_d;
   logic                 grant_id_q, grant_id_d;
   logic                 ack0_q, ack0_d;
   logic                 ack1_q, ack1_d;
   logic                 txd_q, txd_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 tick;
   logic                 bit_end;
   logic                 grant_sel;

   // Rising edge of the oversample clock; clk16_q resets high so release never fakes a tick.
   assign tick    = uart_clk16 & ~clk16_q;
   assign bit_end = tick && (os_q == OS_LAST);

   always_comb begin
      state_d    = state_q;
      clk16_d    = uart_clk16;
      os_d       = os_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      last_d     = last_q;
      grant_id_d = grant_id_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      done_d     = 1'b0;
      grant_sel  = 1'b0;

      if (tick) begin
         os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // On a tie, serve whoever did not own the previous frame.
               grant_sel  = (req0 && req1) ? ~last_q : req1;
               ack0_d     = ~grant_sel;
               ack1_d     = grant_sel;
               shreg_d    = grant_sel ? data1 : data0;
               grant_id_d = grant_sel;
               last_d     = grant_sel;
               os_d       = '0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               bitcnt_d = '0;
               state_d  = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bitcnt_q == BIT_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line and busy are registered from the next state so they align with ack and done.
      unique case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shreg_d[0];
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q    <= S_IDLE;
         clk16_q    <= 1'b1;
         os_q       <= '0;
         bitcnt_q   <= '0;
         shreg_q    <= '0;
         last_q     <= 1'b1;
         grant_id_q <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk16_q    <= clk16_d;
         os_q       <= os_d;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         last_q     <= last_d;
         grant_id_q <= grant_id_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign txd      = txd_q;
   assign busy     = busy_q;
   assign grant_id = grant_id_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a vector table of single frames plus hand-written
// sequences for ties, back-to-back, busy requests and reset corner cases.
module tb_uart_tx_sched;

   localparam int BIT_CYC = 64;   // 16 ticks of a 4-cycle uart_clk16
   localparam int NV      = 6;

   logic       clk_50m    = 1'b0;
   logic       rst        = 1'b1;
   logic       uart_clk16 = 1'b1;
   logic       req0       = 1'b0;
   logic       req1       = 1'b0;
   logic [7:0] data0      = 8'h00;
   logic [7:0] data1      = 8'h00;
   logic       ack0, ack1, txd, busy, grant_id, done;

   int checks = 0;
   int errors = 0;
   int tcyc   = 0;
   int div    = 0;
   int n_ack0 = 0;
   int n_ack1 = 0;
   int n_done = 0;

   typedef struct {
      logic       r0;
      logic       r1;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       exp_g;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[NV];

   uart_tx_sched #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk_50m   (clk_50m),
      .rst       (rst),
      .uart_clk16(uart_clk16),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
      .ack0      (ack0),
      .ack1      (ack1),
      .txd       (txd),
      .busy      (busy),
      .grant_id  (grant_id),
      .done      (done)
   );

   always #5 clk_50m = ~clk_50m;

   // Advance one cycle: sample pulse outputs at the falling edge, then step the 16x wave.
   task automatic cyc();
      @(negedge clk_50m);
      tcyc++;
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (done) n_done++;
      div        = (div + 1) % 4;
      uart_clk16 = (div < 2);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called in the ack cycle; samples start, 8 data and stop bits at mid-bit.
   task automatic rx_frame(output logic [9:0] bits);
      int t0 = tcyc;
      bits = '1;
      for (int k = 0; k < 10; k++) begin
         while (tcyc < t0 + 32 + BIT_CYC * k) cyc();
         bits[k] = txd;
      end
   endtask

   task automatic wait_done(input string name);
      int n  = 0;
      int d0 = n_done;
      while (n_done == d0 && n < 800) begin
         cyc();
         n++;
      end
      chk(name, 32'(n_done != d0), 32'd1);
   endtask

   function automatic logic [9:0] frame_of(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] bits;
      int a0, a1, dn;

      vecs[0] = '{1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 8'h55};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 8'h3C};
      vecs[2] = '{1'b1, 1'b1, 8'h12, 8'h81, 1'b0, 8'h12};
      vecs[3] = '{1'b1, 1'b1, 8'hC4, 8'h7E, 1'b1, 8'h7E};
      vecs[4] = '{1'b0, 1'b1, 8'hAA, 8'h01, 1'b1, 8'h01};
      vecs[5] = '{1'b1, 1'b1, 8'h80, 8'h99, 1'b0, 8'h80};

      // Reset values
      cyc();
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_acks", 32'({ack1, ack0}), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      cyc();
      rst = 1'b0;
      repeat (3) cyc();

      // Table of single frames
      for (int i = 0; i < NV; i++) begin
         a0 = n_ack0; a1 = n_ack1; dn = n_done;
         req0 = vecs[i].r0; req1 = vecs[i].r1;
         data0 = vecs[i].d0; data1 = vecs[i].d1;
         cyc();
         chk($sformatf("v%0d_ack", i), 32'({ack1, ack0}), vecs[i].exp_g ? 32'd2 : 32'd1);
         chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].exp_g));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
         req0 = 1'b0; req1 = 1'b0;
         rx_frame(bits);
         chk($sformatf("v%0d_frame", i), 32'(bits), 32'(frame_of(vecs[i].exp_byte)));
         wait_done($sformatf("v%0d_done", i));
         chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
         repeat (3) cyc();
         chk($sformatf("v%0d_counts", i), 32'((n_ack0 - a0) + (n_ack1 - a1) + (n_done - dn)), 32'd2);
      end

      // Tie after reset: req0 first, req1 at done+1, then req0 again
      rst = 1'b1; cyc(); rst = 1'b0; cyc();
      data0 = 8'hA0; data1 = 8'h0B; req0 = 1'b1; req1 = 1'b1;
      cyc();
      chk("tie_first", 32'({ack1, ack0}), 32'd1);
      req0 = 1'b0;
      rx_frame(bits);
      chk("tie_frame0", 32'(bits), 32'(frame_of(8'hA0)));
      wait_done("tie_done0");
      cyc();
      chk("tie_second", 32'({ack1, ack0}), 32'd2);
      req1 = 1'b0;
      rx_frame(bits);
      chk("tie_frame1", 32'(bits), 32'(frame_of(8'h0B)));
      wait_done("tie_done1");
      cyc();
      data0 = 8'h33; data1 = 8'hCC; req0 = 1'b1; req1 = 1'b1;
      cyc();
      chk("tie_again", 32'({ack1, ack0}), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      wait_done("tie_done2");
      repeat (2) cyc();

      // Back-to-back on req1 with a single idle gap
      a1 = n_ack1;
      data1 = 8'hFF; req1 = 1'b1;
      cyc();
      chk("b2b_ack_a", 32'(ack1), 32'd1);
      data1 = 8'h00;
      rx_frame(bits);
      chk("b2b_frame_a", 32'(bits), 32'(frame_of(8'hFF)));
      wait_done("b2b_done_a");
      chk("b2b_gap_txd", 32'({txd, ack1}), 32'd2);
      cyc();
      chk("b2b_ack_b", 32'({txd, ack1}), 32'd1);
      req1 = 1'b0;
      rx_frame(bits);
      chk("b2b_frame_b", 32'(bits), 32'(frame_of(8'h00)));
      wait_done("b2b_done_b");
      repeat (5) cyc();
      chk("b2b_acks", 32'(n_ack1 - a1), 32'd2);

      // Request arriving mid-frame waits until done+1
      data0 = 8'h96; req0 = 1'b1;
      cyc();
      chk("busyreq_ack0", 32'(ack0), 32'd1);
      req0 = 1'b0;
      repeat (200) cyc();
      a1 = n_ack1;
      data1 = 8'h69; req1 = 1'b1;
      wait_done("busyreq_done");
      chk("busyreq_no_ack1", 32'(n_ack1 - a1), 32'd0);
      cyc();
      chk("busyreq_ack1", 32'(ack1), 32'd1);
      req1 = 1'b0;
      wait_done("busyreq_done1");
      repeat (2) cyc();

      // Reset during data bit 4 of a req1 frame with req0 pending
      data1 = 8'h5A; req1 = 1'b1;
      cyc();
      chk("mid_ack1", 32'(ack1), 32'd1);
      req1 = 1'b0; data0 = 8'h3C; req0 = 1'b1;
      repeat (352) cyc();
      chk("mid_pre", 32'({busy, grant_id}), 32'd3);
      dn = n_done;
      rst = 1'b1;
      cyc();
      chk("mid_rst_out", 32'({txd, busy, grant_id, ack0, ack1, done}), 32'h20);
      rst = 1'b0;
      cyc();
      chk("mid_regrant", 32'({ack1, ack0, grant_id}), 32'd2);
      chk("mid_no_done", 32'(n_done - dn), 32'd0);
      req0 = 1'b0;
      rx_frame(bits);
      chk("mid_frame", 32'(bits), 32'(frame_of(8'h3C)));
      wait_done("mid_done");
      repeat (2) cyc();

      // Release reset while uart_clk16 is high: first tick waits for the next rising edge
      div = 0; uart_clk16 = 1'b1; rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("clk16_first_cycle", 32'(dut.tick), 32'd0);
      cyc(); #1;
      chk("clk16_low1", 32'(dut.tick), 32'd0);
      cyc(); #1;
      chk("clk16_low2", 32'(dut.tick), 32'd0);
      cyc(); #1;
      chk("clk16_tick", 32'(dut.tick), 32'd1);
      cyc(); #1;
      chk("clk16_tick_width", 32'(dut.tick), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
